sram_arbiter_ctrl: RTL and testbench

- Shares the off-chip 16-bit asynchronous SRAM between two 32-bit requesters inside riscv_cache.
  - Port 0: instruction-cache refill.
  - Port 1: data-cache refill/writeback.
- Each 32-bit word access is split into two half-word SRAM cycles: low half first, then high half.
- Drives the SRAM pins directly and sits between the cache controllers and the board-level SRAM pins.

---
 rtl/sram_arbiter_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl: shares one 16-bit asynchronous SRAM between two 32-bit
// requesters (port 0 = I-cache refill, port 1 = D-cache refill/writeback).
// Each word access runs as two half-word SRAM cycles, low half first.
// All SRAM pins, acks, read data and busy are registered from the next state.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; when it is
// undefined, port 1 has fixed priority over port 0.
module sram_arbiter_ctrl #(
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    input  logic [3:0]        p0_be_i,
    output logic              p0_ack_o,
    output logic [31:0]       p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    input  logic [3:0]        p1_be_i,
    output logic              p1_ack_o,
    output logic [31:0]       p1_rdata_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LO_SETUP = 3'd1,
        ST_LO_STRB  = 3'd2,
        ST_HI_SETUP = 3'd3,
        ST_HI_STRB  = 3'd4,
        ST_ACK      = 3'd5
    } state_t;

    // Last strobe-cycle index of a half-word access.
    localparam logic [2:0] LP_WAIT_LAST = 3'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_wait_cnt;
    logic [2:0]          w_wait_cnt_nxt;

    // Latched transaction (captured on the grant edge).
    logic                r_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [15:0]         r_rd_lo;

    // Data-bus driver state.
    logic                r_dq_oe;
    logic [15:0]         r_dq_out;

    logic                w_any_req;
    logic                w_arb_gnt;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [3:0]          w_sel_be;

    logic                w_is_hi;
    logic                w_is_strb;
    logic [1:0]          w_half_be;
    logic [15:0]         w_half_wd;
    logic                w_ce_n;
    logic                w_oe_n;
    logic                w_we_n;
    logic                w_lb_n;
    logic                w_ub_n;
    logic                w_dq_oe;
    logic [15:0]         w_dq_out;
    logic [ADDR_W:0]     w_sram_addr;

    assign w_any_req = p0_req_i | p1_req_i;
    assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;

`ifdef SRAM_ARB_RR_EN
    logic r_last_gnt;

    // Round-robin pick: on a tie the port not served last wins.
    always_comb begin
        w_arb_gnt = 1'b0;
        if (p0_req_i && p1_req_i) begin
            w_arb_gnt = ~r_last_gnt;
        end else begin
            w_arb_gnt = p1_req_i;
        end
    end

    // Remember the most recent grant; reset value lets port 0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_gnt <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_gnt <= w_arb_gnt;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end
`else
    // Fixed priority: the data-cache port wins any tie.
    always_comb begin
        w_arb_gnt = p1_req_i;
    end
`endif

    // Transaction fields for the next cycle: incoming port in IDLE, latched copy otherwise.
    always_comb begin
        w_sel_we    = r_we;
        w_sel_addr  = r_addr;
        w_sel_wdata = r_wdata;
        w_sel_be    = r_be;
        if (r_state == ST_IDLE) begin
            if (w_arb_gnt) begin
                w_sel_we    = p1_we_i;
                w_sel_addr  = p1_addr_i;
                w_sel_wdata = p1_wdata_i;
                w_sel_be    = p1_be_i;
            end else begin
                w_sel_we    = p0_we_i;
                w_sel_addr  = p0_addr_i;
                w_sel_wdata = p0_wdata_i;
                w_sel_be    = p0_be_i;
            end
        end else begin
            w_sel_we = r_we;
        end
    end

    // Next-state logic: fixed setup/strobe sequence, strobe length set by WAIT_CYCLES.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = 3'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_LO_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LO_SETUP: begin
                w_state_nxt = ST_LO_STRB;
            end
            ST_LO_STRB: begin
                if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_nxt = ST_HI_SETUP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            ST_HI_SETUP: begin
                w_state_nxt = ST_HI_STRB;
            end
            ST_HI_STRB: begin
                if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // SRAM pin decode for the upcoming state; WE_N only falls inside a strobe
    // so address/data are already stable, and a half with no byte enables never writes.
    always_comb begin
        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_lb_n      = 1'b1;
        w_ub_n      = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = r_dq_out;
        w_sram_addr = SRAM_ADDR;
        w_is_hi     = (w_state_nxt == ST_HI_SETUP) || (w_state_nxt == ST_HI_STRB);
        w_is_strb   = (w_state_nxt == ST_LO_STRB) || (w_state_nxt == ST_HI_STRB);
        w_half_be   = w_is_hi ? w_sel_be[3:2] : w_sel_be[1:0];
        w_half_wd   = w_is_hi ? w_sel_wdata[31:16] : w_sel_wdata[15:0];
        case (w_state_nxt)
            ST_LO_SETUP, ST_LO_STRB, ST_HI_SETUP, ST_HI_STRB: begin
                w_ce_n      = 1'b0;
                w_sram_addr = {w_sel_addr, w_is_hi};
                if (w_sel_we) begin
                    w_dq_oe  = 1'b1;
                    w_dq_out = w_half_wd;
                    w_lb_n   = ~w_half_be[0];
                    w_ub_n   = ~w_half_be[1];
                    w_we_n   = ~(w_is_strb && (w_half_be != 2'b00));
                end else begin
                    w_lb_n = 1'b0;
                    w_ub_n = 1'b0;
                    w_oe_n = ~w_is_strb;
                end
            end
            default: begin
                w_ce_n = 1'b1;
            end
        endcase
    end

    // State, wait counter and grant latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0000_0000;
            r_be       <= 4'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_gnt   <= w_arb_gnt;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_be    <= w_sel_be;
            end
        end
    end

    // Registered SRAM pins; reset parks every strobe high and releases the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_ADDR <= '0;
            r_dq_oe   <= 1'b0;
            r_dq_out  <= 16'h0000;
        end else begin
            SRAM_CE_N <= w_ce_n;
            SRAM_OE_N <= w_oe_n;
            SRAM_WE_N <= w_we_n;
            SRAM_LB_N <= w_lb_n;
            SRAM_UB_N <= w_ub_n;
            SRAM_ADDR <= w_sram_addr;
            r_dq_oe   <= w_dq_oe;
            r_dq_out  <= w_dq_out;
        end
    end

    // Read-data capture on the last strobe of each half, ack pulse and busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_lo    <= 16'h0000;
            p0_ack_o   <= 1'b0;
            p1_ack_o   <= 1'b0;
            p0_rdata_o <= 32'h0000_0000;
            p1_rdata_o <= 32'h0000_0000;
            busy_o     <= 1'b0;
        end else begin
            busy_o   <= (w_state_nxt != ST_IDLE);
            p0_ack_o <= (w_state_nxt == ST_ACK) && !r_gnt;
            p1_ack_o <= (w_state_nxt == ST_ACK) && r_gnt;
            if ((r_state == ST_LO_STRB) && (w_state_nxt == ST_HI_SETUP) && !r_we) begin
                r_rd_lo <= SRAM_DQ;
            end
            if ((r_state == ST_HI_STRB) && (w_state_nxt == ST_ACK) && !r_we) begin
                if (r_gnt) begin
                    p1_rdata_o <= {SRAM_DQ, r_rd_lo};
                end else begin
                    p0_rdata_o <= {SRAM_DQ, r_rd_lo};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed self-checking bench for sram_arbiter_ctrl with a behavioural SRAM.
// A second instance with WAIT_CYCLES = 3 covers the stretched-strobe timing.
`timescale 1ns/1ps
module tb_sram_arbiter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [16:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic        p0_ack, p1_ack, busy;
    logic [31:0] p0_rdata, p1_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    // Second instance (WAIT_CYCLES = 3)
    logic        r3_req;
    logic [16:0] r3_addr;
    logic        ack3_0, ack3_1, busy3;
    logic [31:0] rdata3_0, rdata3_1;
    logic [17:0] addr3;
    wire  [15:0] dq3;
    logic        ce3, oe3, we3, lb3, ub3;

    // SRAM model
    logic [15:0] mem [0:262143];
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [15:0] pl_data;

    int n_cmp;
    int n_err;

    logic [63:0] tr_ce, tr_oe, tr_we, tr_lb, tr_ub, tr_ack0, tr_ack1;
    logic [17:0] tr_addr [0:63];
    logic [15:0] tr_dq   [0:63];

    sram_arbiter_ctrl #(.ADDR_W(17), .WAIT_CYCLES(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_be_i(p0_be), .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_be_i(p1_be), .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
        .busy_o(busy), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    sram_arbiter_ctrl #(.ADDR_W(17), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(r3_req), .p0_we_i(1'b0), .p0_addr_i(r3_addr), .p0_wdata_i(32'h0000_0000),
        .p0_be_i(4'h0), .p0_ack_o(ack3_0), .p0_rdata_o(rdata3_0),
        .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(17'h00000), .p1_wdata_i(32'h0000_0000),
        .p1_be_i(4'h0), .p1_ack_o(ack3_1), .p1_rdata_o(rdata3_1),
        .busy_o(busy3), .SRAM_ADDR(addr3), .SRAM_DQ(dq3),
        .SRAM_CE_N(ce3), .SRAM_OE_N(oe3), .SRAM_WE_N(we3),
        .SRAM_LB_N(lb3), .SRAM_UB_N(ub3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;
    assign dq3     = (!ce3 && !oe3) ? (addr3[15:0] ^ 16'h5A5A) : 16'hzzzz;

    // SRAM array: preload port for the bench, byte-lane writes while CE_N and WE_N are low.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic sram_load(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic clear_trace();
        tr_ce = '0; tr_oe = '0; tr_we = '0; tr_lb = '0; tr_ub = '0;
        tr_ack0 = '0; tr_ack1 = '0;
        for (int i = 0; i < 64; i++) begin
            tr_addr[i] = 18'h0;
            tr_dq[i]   = 16'h0;
        end
    endtask

    task automatic sample(input int k);
        tr_ce[k-1]   = ce_n;
        tr_oe[k-1]   = oe_n;
        tr_we[k-1]   = we_n;
        tr_lb[k-1]   = lb_n;
        tr_ub[k-1]   = ub_n;
        tr_ack0[k-1] = p0_ack;
        tr_ack1[k-1] = p1_ack;
        tr_addr[k-1] = sram_addr;
        tr_dq[k-1]   = sram_dq;
    endtask

    // One transaction on one port; cycle 1 is the cycle after the grant edge.
    task automatic do_txn(input logic port, input logic we, input logic [16:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, output int lat);
        @(negedge clk);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be;
        end
        clear_trace();
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            sample(k);
            if (port ? p1_ack : p0_ack) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          n0, n1, norder, last_cyc, ack_seen, lat3;
        logic [5:0]  order;
        logic [19:0] oe3v;

        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 17'h0; p0_wdata = 32'h0; p0_be = 4'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 17'h0; p1_wdata = 32'h0; p1_be = 4'h0;
        r3_req = 1'b0; r3_addr = 17'h0;
        pl_en = 1'b0; pl_addr = 18'h0; pl_data = 16'h0;
        clear_trace();

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        check_val("rst_addr", sram_addr, 18'h0);
        check_val("rst_busy_ack", {busy, p0_ack, p1_ack}, 3'b000);
        check_val("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
        rst_n = 1'b1;

        // 1: port 0 read
        sram_load(18'h00020, 16'h1234);
        sram_load(18'h00021, 16'hABCD);
        do_txn(1'b0, 1'b0, 17'h00010, 32'h0, 4'hF, lat);
        check_val("t1_lat", lat, 5);
        check_val("t1_rdata", p0_rdata, 32'hABCD1234);
        check_val("t1_p1ack", tr_ack1[4:0], 5'b00000);
        check_val("t1_ce", tr_ce[4:0], 5'b10000);
        check_val("t1_oe", tr_oe[4:0], 5'b10101);
        check_val("t1_we", tr_we[4:0], 5'b11111);
        check_val("t1_lbub", {tr_lb[3:0], tr_ub[3:0]}, 8'h00);
        check_val("t1_addr_lo", tr_addr[1], 18'h00020);
        check_val("t1_addr_hi", tr_addr[3], 18'h00021);
        @(negedge clk);
        check_val("t1_ack_pulse", {p0_ack, busy}, 2'b00);

        // 2: port 1 partial write
        sram_load(18'h3FFFE, 16'h1111);
        sram_load(18'h3FFFF, 16'h1111);
        do_txn(1'b1, 1'b1, 17'h1FFFF, 32'hDEADBEEF, 4'b0110, lat);
        check_val("t2_lat", lat, 5);
        check_val("t2_we", tr_we[4:0], 5'b10101);
        check_val("t2_oe", tr_oe[4:0], 5'b11111);
        check_val("t2_lbub_lo", {tr_lb[1], tr_ub[1]}, 2'b10);
        check_val("t2_lbub_hi", {tr_lb[3], tr_ub[3]}, 2'b01);
        check_val("t2_dq_lo", tr_dq[1], 16'hBEEF);
        check_val("t2_dq_hi", tr_dq[3], 16'hDEAD);
        check_val("t2_addr_lo", tr_addr[1], 18'h3FFFE);
        check_val("t2_addr_hi", tr_addr[3], 18'h3FFFF);
        check_val("t2_p0ack", tr_ack0[4:0], 5'b00000);
        check_val("t2_mem_lo", mem[18'h3FFFE], 16'hBE11);
        check_val("t2_mem_hi", mem[18'h3FFFF], 16'h11AD);
        check_val("t2_rdata_keep", p1_rdata, 32'h0);

        // 3: simultaneous held reads, three transactions per port
        sram_load(18'h00200, 16'hC0DE);
        sram_load(18'h00201, 16'h600D);
        sram_load(18'h00400, 16'hFACE);
        sram_load(18'h00401, 16'hB00C);
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 17'h00100;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 17'h00200;
        n0 = 0; n1 = 0; norder = 0; order = 6'b0; last_cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (p0_ack && norder < 6) begin
                order[norder] = 1'b0; norder++; n0++;
                if (n0 == 3) p0_req = 1'b0;
            end
            if (p1_ack && norder < 6) begin
                order[norder] = 1'b1; norder++; n1++;
                if (n1 == 3) p1_req = 1'b0;
            end
            if (n0 == 3 && n1 == 3) begin
                last_cyc = c;
                break;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
        check_val("t3_order_rr", order, 6'b101010);
`else
        check_val("t3_order_fixed", order, 6'b000111);
`endif
        check_val("t3_last_cycle", last_cyc, 35);
        check_val("t3_p0_rdata", p0_rdata, 32'h600DC0DE);
        check_val("t3_p1_rdata", p1_rdata, 32'hB00CFACE);

        // 4: write on port 1 then queued read on port 0 (bus turnaround)
        sram_load(18'h00602, 16'h5555);
        sram_load(18'h00603, 16'hAAAA);
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 17'h00300; p1_wdata = 32'h0F0FF0F0; p1_be = 4'hF;
        clear_trace();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                p1_req = 1'b0;
                p0_req = 1'b1; p0_we = 1'b0; p0_addr = 17'h00301;
            end
            if (k == 7) p0_req = 1'b0;
            sample(k);
        end
        check_val("t4_oe", tr_oe[10:0], 11'h57F);
        check_val("t4_we", tr_we[10:0], 11'h7F5);
        check_val("t4_ack1", tr_ack1[10:0], 11'h010);
        check_val("t4_ack0", tr_ack0[10:0], 11'h400);
        check_val("t4_dq_w", {tr_dq[1], tr_dq[3]}, 32'hF0F00F0F);
        check_val("t4_dq_r", {tr_dq[7], tr_dq[9]}, 32'h5555AAAA);
        check_val("t4_rdata", p0_rdata, 32'hAAAA5555);
        check_val("t4_mem", {mem[18'h00601], mem[18'h00600]}, 32'h0F0FF0F0);

        // 5: reset during the high strobe of a write
        sram_load(18'h00800, 16'h0000);
        sram_load(18'h00801, 16'h0000);
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 17'h00400; p0_wdata = 32'h12345678; p0_be = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) p0_req = 1'b0;
        end
        check_val("t5_in_strobe", {ce_n, we_n, sram_addr}, {2'b00, 18'h00801});
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        check_val("t5_rst_busy_ack", {busy, p0_ack, p1_ack}, 3'b000);
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (p0_ack || p1_ack) ack_seen = 1;
        end
        rst_n = 1'b1;
        check_val("t5_no_ack", ack_seen, 0);
        check_val("t5_mem_hi", mem[18'h00801], 16'h0000);
        check_val("t5_mem_lo", mem[18'h00800], 16'h5678);
        check_val("t5_rdata_rst", p0_rdata, 32'h0);
        do_txn(1'b0, 1'b0, 17'h00400, 32'h0, 4'hF, lat);
        check_val("t5_lat_after", lat, 5);
        check_val("t5_rdata_after", p0_rdata, 32'h00005678);

        // 6: WAIT_CYCLES = 3 read
        @(negedge clk);
        r3_req = 1'b1; r3_addr = 17'h00055;
        lat3 = 0; oe3v = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) r3_req = 1'b0;
            oe3v[k-1] = oe3;
            if (ack3_0) begin
                lat3 = k;
                break;
            end
        end
        check_val("t6_lat", lat3, 9);
        check_val("t6_oe", oe3v[8:0], 9'h111);
        check_val("t6_rdata", rdata3_0, 32'h5AF15AF0);
        check_val("t6_p1ack", ack3_1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
